axi_8bit_adder_stage: RTL and testbench

AXI-Stream adder stage sitting directly upstream of the 16-bit stream receiver. It accepts two independent 8-bit operand streams (A, B) and joins them pairwise in arrival order. It emits each sum as a 16-bit AXI-Stream beat. Fully synthesizable; tolerates arbitrary downstream backpressure, including the receiver's multi-cycle ready-low periods, at one sum per cycle sustained throughput.

---
 rtl/axi_8bit_adder_stage_pkg.sv | 7 +
 rtl/axi_8bit_adder_stage_skid_fifo2.sv | 37 +++
 rtl/axi_8bit_adder_stage.sv | 58 +++++
 tb/tb_axi_8bit_adder_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_8bit_adder_stage_pkg.sv
// axi_8bit_adder_stage_pkg: shared widths and output FIFO depth for the adder stage family
package axi_8bit_adder_stage_pkg;
  localparam int DEF_IN_WIDTH = 8;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int FIFO_DEPTH = 2;
  typedef logic [1:0] fifo_cnt_t;
endpackage

// File: rtl/axi_8bit_adder_stage_skid_fifo2.sv
// axi_skid_fifo2: 2-entry register FIFO, push/space in, AXI-Stream master out
module axi_skid_fifo2
  import axi_8bit_adder_stage_pkg::*;
#(
  parameter int W = DEF_OUT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         space,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);
  localparam fifo_cnt_t FULL = fifo_cnt_t'(FIFO_DEPTH);
  fifo_cnt_t count;
  logic [W-1:0] e0, e1;
  logic pop;
  assign m_valid = count != 2'd0;
  assign m_data = e0;
  assign space = count != FULL;
  assign pop = m_valid & m_ready;
  // e0 is always the head; the caller never pushes while full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      count <= count + fifo_cnt_t'(push) - fifo_cnt_t'(pop);
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) e0 <= push_data;
      else if (pop && count == FULL) e0 <= e1;
      if (push && count == 2'd1 && !pop) e1 <= push_data;
    end
  end
endmodule

// File: rtl/axi_8bit_adder_stage.sv
// axi_8bit_adder_stage: joins two operand streams pairwise and emits their sum as a stream
module axi_8bit_adder_stage
  import axi_8bit_adder_stage_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  s_axis_a_data,
  input  logic                 s_axis_a_valid,
  output logic                 s_axis_a_ready,
  input  logic [IN_WIDTH-1:0]  s_axis_b_data,
  input  logic                 s_axis_b_valid,
  output logic                 s_axis_b_ready,
  output logic [OUT_WIDTH-1:0] m_axis_data,
  output logic                 m_axis_valid,
  input  logic                 m_axis_ready,
  output logic [15:0]          sum_count
);
  logic a_full, b_full, a_acc, b_acc, join_fire, space;
  logic [IN_WIDTH-1:0] a_hold, b_hold;
  logic [OUT_WIDTH-1:0] a_ext, b_ext;
  // join looks only at registered FIFO occupancy, keeping m_axis_ready off the input ready path
  assign join_fire = a_full & b_full & space;
  assign s_axis_a_ready = !a_full | join_fire;
  assign s_axis_b_ready = !b_full | join_fire;
  assign a_acc = s_axis_a_valid & s_axis_a_ready;
  assign b_acc = s_axis_b_valid & s_axis_b_ready;
  assign a_ext = {{(OUT_WIDTH-IN_WIDTH){SIGNED & a_hold[IN_WIDTH-1]}}, a_hold};
  assign b_ext = {{(OUT_WIDTH-IN_WIDTH){SIGNED & b_hold[IN_WIDTH-1]}}, b_hold};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
      a_hold <= '0;
      b_hold <= '0;
      sum_count <= '0;
    end else begin
      a_full <= a_acc | (a_full & !join_fire);
      b_full <= b_acc | (b_full & !join_fire);
      if (a_acc) a_hold <= s_axis_a_data;
      if (b_acc) b_hold <= s_axis_b_data;
      if (m_axis_valid && m_axis_ready) sum_count <= sum_count + 16'd1;
    end
  end
  axi_skid_fifo2 #(.W(OUT_WIDTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(join_fire),
    .push_data(a_ext + b_ext),
    .space(space),
    .m_data(m_axis_data),
    .m_valid(m_axis_valid),
    .m_ready(m_axis_ready)
  );
endmodule

// File: tb/tb_axi_8bit_adder_stage.sv
// tb_axi_8bit_adder_stage: directed checks of the adder stage, unsigned and signed instances side by side
module tb_axi_8bit_adder_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic a_valid = 1'b0, b_valid = 1'b0, m_ready = 1'b0;
  logic a_ready, b_ready, m_valid, s_a_ready, s_b_ready, s_valid;
  logic [15:0] m_data, s_data, sum_count, s_count;
  int total = 0, bad = 0, cyc = 0;
  logic [15:0] got[$], gots[$], expq[$], exps[$];
  int gotc[$];
  logic pv = 1'b0, pr = 1'b0, done = 1'b0;
  logic [15:0] pd = '0;
  logic [7:0] ra, rb;

  always #5 clk = ~clk;

  axi_8bit_adder_stage u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_a_data(a_data), .s_axis_a_valid(a_valid), .s_axis_a_ready(a_ready),
    .s_axis_b_data(b_data), .s_axis_b_valid(b_valid), .s_axis_b_ready(b_ready),
    .m_axis_data(m_data), .m_axis_valid(m_valid), .m_axis_ready(m_ready),
    .sum_count(sum_count)
  );

  axi_8bit_adder_stage #(.SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n),
    .s_axis_a_data(a_data), .s_axis_a_valid(a_valid), .s_axis_a_ready(s_a_ready),
    .s_axis_b_data(b_data), .s_axis_b_valid(b_valid), .s_axis_b_ready(s_b_ready),
    .m_axis_data(s_data), .m_axis_valid(s_valid), .m_axis_ready(m_ready),
    .sum_count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    a_data = a; b_data = b; a_valid = 1'b1; b_valid = 1'b1;
    while (!(a_ready && b_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("pair_accept", {31'b0, a_ready & b_ready}, 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      got.push_back(m_data);
      gots.push_back(s_data);
      gotc.push_back(cyc);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rst_n && pv && !pr) begin
      chk("hold_valid", {31'b0, m_valid}, 32'd1);
      chk("hold_data", {16'b0, m_data}, {16'b0, pd});
    end
    pv = rst_n & m_valid; pr = m_ready; pd = m_data;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_a_ready", {31'b0, a_ready}, 32'd1);
    chk("rst_b_ready", {31'b0, b_ready}, 32'd1);
    chk("rst_count", {16'b0, sum_count}, 32'd0);
    chk("rst_data", {16'b0, m_data}, 32'd0);
    // basic add, 2-cycle latency
    @(posedge clk); #1;
    a_data = 8'hFF; b_data = 8'hFF; a_valid = 1'b1; b_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("basic_latency", {31'b0, m_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("basic_valid", {31'b0, m_valid}, 32'd1);
    chk("basic_data", {16'b0, m_data}, 32'h01FE);
    chk("basic_signed", {16'b0, s_data}, 32'hFFFE);
    @(posedge clk); @(negedge clk);
    chk("basic_done", {31'b0, m_valid}, 32'd0);
    chk("basic_count", {16'b0, sum_count}, 32'd1);
    // skewed arrival
    @(posedge clk); #1;
    a_data = 8'd10; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("skew_hold", {31'b0, a_ready}, 32'd0);
      @(posedge clk); #1;
    end
    b_data = 8'd20; b_valid = 1'b1;
    @(negedge clk);
    chk("skew_hold_last", {31'b0, a_ready}, 32'd0);
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("skew_valid", {31'b0, m_valid}, 32'd1);
    chk("skew_data", {16'b0, m_data}, 32'd30);
    chk("skew_signed", {16'b0, s_data}, 32'd30);
    @(posedge clk); @(negedge clk);
    chk("skew_count", {16'b0, sum_count}, 32'd2);
    // backpressure
    @(posedge clk); #1;
    m_ready = 1'b0;
    got.delete();
    push_pair(8'd1, 8'd1);
    push_pair(8'd2, 8'd2);
    push_pair(8'd3, 8'd3);
    a_data = 8'd4; b_data = 8'd4; a_valid = 1'b1; b_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_a_ready", {31'b0, a_ready}, 32'd0);
      chk("bp_b_ready", {31'b0, b_ready}, 32'd0);
      chk("bp_head", {16'b0, m_data}, 32'd2);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    push_pair(8'd4, 8'd4);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bp_size", got.size(), 32'd4);
    chk("bp_out0", {16'b0, got[0]}, 32'd2);
    chk("bp_out1", {16'b0, got[1]}, 32'd4);
    chk("bp_out2", {16'b0, got[2]}, 32'd6);
    chk("bp_out3", {16'b0, got[3]}, 32'd8);
    chk("bp_count", {16'b0, sum_count}, 32'd6);
    // signed vs unsigned extension
    got.delete(); gots.delete();
    push_pair(8'h80, 8'h80);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sgn_size", gots.size(), 32'd1);
    chk("sgn_data", {16'b0, gots[0]}, 32'hFF00);
    chk("uns_data", {16'b0, got[0]}, 32'h0100);
    // reset with two sums queued
    @(posedge clk); #1;
    m_ready = 1'b0;
    push_pair(8'd5, 8'd5);
    push_pair(8'd6, 8'd6);
    @(posedge clk); @(negedge clk);
    chk("mid_valid", {31'b0, m_valid}, 32'd1);
    chk("mid_head", {16'b0, m_data}, 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, m_valid}, 32'd0);
    chk("mid_rst_count", {16'b0, sum_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; m_ready = 1'b1;
    got.delete();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid_no_stale", got.size(), 32'd0);
    chk("mid_idle", {31'b0, m_valid}, 32'd0);
    // throughput
    @(posedge clk); #1;
    got.delete(); gotc.delete();
    for (int i = 0; i < 100; i++) push_pair(8'(i), 8'(3 * i));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("tp_size", got.size(), 32'd100);
    for (int i = 0; i < 100; i++) chk("tp_data", {16'b0, got[i]}, 32'(i + ((3 * i) & 255)));
    chk("tp_rate", 32'(gotc[99] - gotc[0]), 32'd99);
    chk("tp_count", {16'b0, sum_count}, 32'd100);
    // random downstream ready
    @(posedge clk); #1;
    got.delete(); gots.delete(); expq.delete(); exps.delete();
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          ra = 8'($urandom); rb = 8'($urandom);
          expq.push_back({8'b0, ra} + {8'b0, rb});
          exps.push_back({{8{ra[7]}}, ra} + {{8{rb[7]}}, rb});
          push_pair(ra, rb);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("rx_size", got.size(), 32'd30);
    for (int i = 0; i < 30; i++) begin
      chk("rx_data", {16'b0, got[i]}, {16'b0, expq[i]});
      chk("rx_signed", {16'b0, gots[i]}, {16'b0, exps[i]});
    end
    chk("rx_count", {16'b0, sum_count}, 32'd130);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
